// File: rtl/mux_pkg.sv
// Shared definitions for the 8:1 serializer: FSM state encoding and the
// bit-index constants that define where a word starts and ends.
package mux_pkg;

  // FSM state encoding; PARITY is only reachable when SER_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit index of the first bit presented for each bit order.
  localparam logic [2:0] FIRST_LSB = 3'd0;
  localparam logic [2:0] FIRST_MSB = 3'd7;

endpackage

// File: rtl/serializer_8x1_if.sv
// Handshake bundle for serializer_8x1: parallel load side, serial side and
// the observe signals (bit index and FSM state).
//
// Valid/ready rule on both sides: a transfer happens on a rising clk edge
// where valid && ready. A source that raises valid keeps it high with its
// data unchanged until that transfer; ready may change freely.
interface serializer_8x1_if;

  logic                  load_valid;
  logic [7:0]            load_data;
  logic                  load_ready;
  logic                  ser_ready;
  logic                  ser_valid;
  logic                  ser_out;
  logic                  ser_last;
  logic [2:0]            sel;
  mux_pkg::state_t       state;

  // Environment side: supplies words and consumes bits.
  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_valid, ser_out, ser_last, sel, state
  );

  // Serializer side.
  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_valid, ser_out, ser_last, sel, state
  );

endinterface

// File: rtl/mux_8x1.sv
// Plain 8:1 bit select used as the serializer's output data path.
module mux_8x1 (
  input  logic [7:0] inp,
  input  logic [2:0] sel,
  output logic       out
);

  assign out = inp[sel];

endmodule

// File: rtl/serializer_8x1.sv
// 8-bit parallel-to-serial converter with valid/ready on both sides.
// A word loaded on one edge is presented bit by bit from the next cycle;
// a new word may be accepted on the final-bit transfer for gap-free output.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit per word.
module serializer_8x1
  import mux_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  serializer_8x1_if.slave bus
);

  localparam logic [2:0] START_IDX = MSB_FIRST ? FIRST_MSB : FIRST_LSB;
  localparam logic [2:0] LAST_IDX  = MSB_FIRST ? FIRST_LSB : FIRST_MSB;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] holding_q;
  logic [2:0] sel_q;
  logic       mux_bit;
  logic       ser_valid;
  logic       ser_out;
  logic       ser_last;
  logic       load_ready;
  logic       load;
  logic       xfer;
`ifdef SER_PARITY_EN
  logic       parity_q;
`endif

  mux_8x1 u_mux (
    .inp (holding_q),
    .sel (sel_q),
    .out (mux_bit)
  );

  // A new word can enter when idle or when the final bit leaves this cycle.
  assign load_ready = (state_q == IDLE) || (ser_last && bus.ser_ready);
  assign load       = bus.load_valid && load_ready;
  assign xfer       = ser_valid && bus.ser_ready;

  // Output decode from the current state; idle drives all zeros.
  always_comb begin
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    case (state_q)
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = mux_bit;
`ifndef SER_PARITY_EN
        ser_last  = (sel_q == LAST_IDX);
`endif
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = parity_q;
        ser_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic; a load on the final transfer keeps the FSM in SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) state_d = SHIFT;
      end
      SHIFT: begin
        if (xfer && (sel_q == LAST_IDX)) begin
`ifdef SER_PARITY_EN
          state_d = PARITY;
`else
          state_d = load ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        if (xfer) state_d = load ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Holding register, bit index and parity accumulator; all frozen on a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      holding_q <= 8'h00;
      sel_q     <= START_IDX;
`ifdef SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (load) begin
      holding_q <= bus.load_data;
      sel_q     <= START_IDX;
`ifdef SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (xfer && (state_q == SHIFT)) begin
`ifdef SER_PARITY_EN
      parity_q  <= parity_q ^ mux_bit;
`endif
      if (sel_q == LAST_IDX) sel_q <= START_IDX;
      else if (MSB_FIRST)    sel_q <= sel_q - 3'd1;
      else                   sel_q <= sel_q + 3'd1;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_valid  = ser_valid;
  assign bus.ser_out    = ser_out;
  assign bus.ser_last   = ser_last;
  assign bus.sel        = sel_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_serializer_8x1.sv
// Table-driven bench for serializer_8x1: one LSB-first and one MSB-first
// instance receive identical stimulus; every row lists inputs and the
// expected outputs seen before the next rising edge.
module tb_serializer_8x1;
  import mux_pkg::*;

`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  serializer_8x1_if bus_l ();
  serializer_8x1_if bus_m ();

  serializer_8x1 #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus_l.slave));
  serializer_8x1 #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus_m.slave));

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic       lv;
    logic [7:0] ld;
    logic       sr;
    logic       sv;
    logic       so_l;
    logic       so_m;
    logic       sl;
    logic       lr;
    logic [2:0] sel_l;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add_row(input logic rn, input logic lv, input logic [7:0] ld,
                         input logic sr, input logic sv, input logic so_l,
                         input logic so_m, input logic sl, input logic lr,
                         input logic [2:0] sel_l);
    vec_t v;
    v.rst_n = rn;   v.lv = lv;     v.ld = ld;     v.sr = sr;
    v.sv    = sv;   v.so_l = so_l; v.so_m = so_m; v.sl = sl;
    v.lr    = lr;   v.sel_l = sel_l;
    tbl.push_back(v);
  endtask

  // Idle cycle, optionally offering a word (accepted since idle is ready).
  task automatic add_idle(input logic lv, input logic [7:0] ld);
    add_row(1'b1, lv, ld, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
  endtask

  // Bits of word w; nlv/nld is what upstream offers meanwhile, and
  // ser_ready drops for stall_len cycles while bit stall_at is shown.
  task automatic add_word(input logic [7:0] w, input logic nlv, input logic [7:0] nld,
                          input int stall_at, input int stall_len);
    logic last;
    for (int i = 0; i < 8; i++) begin
      last = (i == 7) && !PAR;
      if (i == stall_at)
        for (int k = 0; k < stall_len; k++)
          add_row(1'b1, nlv, nld, 1'b0, 1'b1, w[i], w[7-i], last, 1'b0, 3'(i));
      add_row(1'b1, nlv, nld, 1'b1, 1'b1, w[i], w[7-i], last, last, 3'(i));
    end
    if (PAR) add_row(1'b1, nlv, nld, 1'b1, 1'b1, ^w, ^w, 1'b1, 1'b1, 3'd0);
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic lv, input logic [7:0] ld, input logic sr);
    rst_n            = rn;
    bus_l.load_valid = lv;  bus_m.load_valid = lv;
    bus_l.load_data  = ld;  bus_m.load_data  = ld;
    bus_l.ser_ready  = sr;  bus_m.ser_ready  = sr;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Basic word, LSB order 1,1,0,0,1,1,0,1 and MSB order 1,0,1,1,0,0,1,1.
    add_idle(1'b1, 8'b1011_0011);
    add_word(8'b1011_0011, 1'b0, 8'h00, -1, 0);
    add_idle(1'b0, 8'h00);
    // Back-to-back words with load_valid held; 3C offered while busy is ignored.
    add_idle(1'b1, 8'hA5);
    add_word(8'hA5, 1'b1, 8'h3C, -1, 0);
    add_word(8'h3C, 1'b0, 8'h00, -1, 0);
    add_idle(1'b0, 8'h00);
    // Stall for 3 cycles at bit 4.
    add_idle(1'b1, 8'h96);
    add_word(8'h96, 1'b0, 8'h00, 4, 3);
    add_idle(1'b1, 8'h5A);
    // Stall on the final bit while the next word waits.
    add_word(8'h5A, 1'b1, 8'hC3, 7, 2);
    add_word(8'hC3, 1'b0, 8'h00, -1, 0);
    add_idle(1'b0, 8'h00);
    // Reset sampled while bit 5 of FF is shown aborts the word.
    add_idle(1'b1, 8'hFF);
    for (int i = 0; i < 5; i++)
      add_row(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
    add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    add_idle(1'b0, 8'h00);
    add_idle(1'b0, 8'h00);
    // Parity-relevant words (odd and zero weight).
    add_idle(1'b1, 8'b0000_0111);
    add_word(8'b0000_0111, 1'b0, 8'h00, -1, 0);
    add_idle(1'b1, 8'h00);
    add_word(8'h00, 1'b0, 8'h00, -1, 0);
    add_idle(1'b0, 8'h00);

    // Reset: two edges with rst_n low, then check the reset state.
    drive(1'b0, 1'b1, 8'hEE, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    chk("rst_ser_valid",  -1, bus_l.ser_valid,  8'd0);
    chk("rst_ser_out",    -1, bus_l.ser_out,    8'd0);
    chk("rst_ser_last",   -1, bus_l.ser_last,   8'd0);
    chk("rst_load_ready", -1, bus_l.load_ready, 8'd1);
    chk("rst_sel_lsb",    -1, bus_l.sel,        8'd0);
    chk("rst_sel_msb",    -1, bus_m.sel,        8'd7);
    chk("rst_state",      -1, bus_l.state,      IDLE);
    @(posedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      vec_t v;
      v = tbl[r];
      @(negedge clk);
      drive(v.rst_n, v.lv, v.ld, v.sr);
      #1;
      chk("lsb_ser_valid",  r, bus_l.ser_valid,  v.sv);
      chk("lsb_ser_out",    r, bus_l.ser_out,    v.so_l);
      chk("lsb_ser_last",   r, bus_l.ser_last,   v.sl);
      chk("lsb_load_ready", r, bus_l.load_ready, v.lr);
      chk("lsb_sel",        r, bus_l.sel,        v.sel_l);
      chk("msb_ser_valid",  r, bus_m.ser_valid,  v.sv);
      chk("msb_ser_out",    r, bus_m.ser_out,    v.so_m);
      chk("msb_ser_last",   r, bus_m.ser_last,   v.sl);
      chk("msb_load_ready", r, bus_m.load_ready, v.lr);
      chk("msb_sel",        r, bus_m.sel,        3'd7 - v.sel_l);
      @(posedge clk);
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer_8x1.md
SERIALIZER_8X1 -- requirements
Module: serializer_8x1

Interface
REQ-001 Parameter: MSB_FIRST, default 0, 0 = bit 0 sent first, 1 = bit 7 sent first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 load_valid  input  1  upstream word available.
REQ-005 load_data  input  8  parallel word to serialize.
REQ-006 load_ready  output  1  block accepts load_data this cycle.
REQ-007 ser_ready  input  1  downstream accepts current serial bit.
REQ-008 ser_valid  output  1  ser_out carries a valid bit.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 ser_last  output  1  current bit is final bit of the word.
REQ-011 sel  output  3  current bit index driving the internal 8:1 select (debug/observe).

Function
REQ-012 Load accepted on a rising edge where load_valid && load_ready; load_data captured into an 8-bit holding register.
REQ-013 FSM states: IDLE, SHIFT (plus PARITY when SER_PARITY_EN is defined).
REQ-014 IDLE -> SHIFT on accepted load; first bit presented the cycle after acceptance (latency 1 cycle).
REQ-015 In SHIFT: ser_valid=1; ser_out = holding[sel] via the 8:1 mux; bit advances only on a cycle where ser_valid && ser_ready.
REQ-016 sel starts at 0 (MSB_FIRST=0) or 7 (MSB_FIRST=1); it increments or decrements by 1 per transferred bit, with no wrap inside a word.
REQ-017 ser_last=1 while the final data bit is presented (sel=7, or sel=0 for MSB_FIRST), unless parity is enabled.
REQ-018 load_ready = (state==IDLE) || (ser_last && ser_ready), combinational; this permits back-to-back words with no idle bubble.
REQ-019 Final bit transferred with no new load: -> IDLE; with a simultaneous new load: stay in SHIFT, reload sel to start index, capture the new word.
REQ-020 ser_ready low: ser_out, sel, ser_last and the holding register stay stable; ser_valid stays 1 (no retraction).
REQ-021 In IDLE: ser_valid=0, ser_last=0, ser_out=0, sel holds start index.
REQ-022 load_valid while load_ready=0 is ignored; the upstream source must hold its word.

Reset
REQ-023 While rst_n=0 at a rising edge: state=IDLE, holding register=0, sel=start index, parity accumulator=0.
REQ-024 Reset values after that edge: ser_valid=0, ser_out=0, ser_last=0, load_ready=1.
REQ-025 Reset mid-word aborts the word immediately; remaining bits are never output.

Configuration
REQ-026 Macro SER_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) follows the data as a 9th bit in state PARITY, and ser_last asserts only on that bit.
REQ-027 Without SER_PARITY_EN: no PARITY state, and each word is exactly 8 transfers.

Structure
REQ-028 Shared package mux_pkg holds the FSM state encoding constants (IDLE=0, SHIFT=1, PARITY=2) and the bit-index constants (FIRST_LSB=0, FIRST_MSB=7).
REQ-029 The bit-select path instantiates the existing mux_8x1 as its single sub-module (inp=holding register, sel=sel, out=ser_out source).

Verification
REQ-030 Load 8'b10110011, ser_ready=1, MSB_FIRST=0 -> ser_out sequence 1,1,0,0,1,1,0,1 on 8 consecutive cycles; ser_last on cycle 8; back to IDLE.
REQ-031 Same word with MSB_FIRST=1 -> ser_out sequence 1,0,1,1,0,0,1,1; sel counts 7 down to 0.
REQ-032 Two words (8'hA5 then 8'h3C) with load_valid held -> 16 contiguous valid bits with no gap; second load accepted on the ser_last cycle.
REQ-033 Drop ser_ready for 3 cycles at bit 4 -> ser_out, sel and ser_last stay frozen; sequence resumes with no lost or repeated bit.
REQ-034 rst_n=0 at bit 5 of 8'hFF -> next cycle ser_valid=0, load_ready=1, sel=0; no further bits of that word appear.
REQ-035 SER_PARITY_EN defined, load 8'b00000111 -> 8 data bits then parity bit 1 with ser_last=1; 8'h00 -> parity bit 0.
